// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, state encoding and ratio clamp for the programmable divider
package clk_div_pkg;

  localparam int DIV_WIDTH_DEF = 8;
  localparam int MIN_RATIO     = 2;
  localparam int RST_RATIO_DEF = 2;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  // Ratios below MIN_RATIO cannot produce both a high and a low phase.
  function automatic int clamp_ratio(input int r);
    return (r < MIN_RATIO) ? MIN_RATIO : r;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// rtl/clk_div_if.sv - control and divided-clock signal bundle for clk_div_prog
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
);

  logic                 en;
  logic [DIV_WIDTH-1:0] div_ratio;
  logic                 div_load;
  logic                 div_ack;
  logic                 busy;
  logic                 clk_out;
  logic                 tick;

  modport master (
    output en, div_ratio, div_load,
    input  div_ack, busy, clk_out, tick
  );

  modport slave (
    input  en, div_ratio, div_load,
    output div_ack, busy, clk_out, tick
  );

endinterface

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter, high-time compare, registered clk_out and tick
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] n_a,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 wrap
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_next;
  logic [DIV_WIDTH-1:0] high_time;
  // Set while stopped; keeps clk_out low for the whole first period so the
  // first rising edge lands on the first wrap.
  logic                 primed;

  // ceil(n_a/2) without needing an extra carry bit
  assign high_time = (n_a >> 1) + DIV_WIDTH'(n_a[0]);
  assign wrap      = run && (cnt >= (n_a - DIV_WIDTH'(1)));

  // Next count: advance while running, wrap at n_a-1, park at 0 when stopped
  always_comb begin
    cnt_next = '0;
    if (run && !wrap) begin
      cnt_next = cnt + DIV_WIDTH'(1);
    end
  end

  // Count, clk_out and tick all registered from the next count value
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      primed  <= 1'b1;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      tick    <= wrap;
      clk_out <= run && (cnt_next < high_time) && (!primed || wrap);
      if (!run) begin
        primed <= 1'b1;
      end else if (wrap) begin
        primed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with glitch-free ratio update handshake
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int RST_RATIO = RST_RATIO_DEF
) (
  input  logic      clk_in,
  input  logic      rst,
  clk_div_if.slave  bus
);

  localparam logic [DIV_WIDTH-1:0] RST_CLAMPED = DIV_WIDTH'(clamp_ratio(RST_RATIO));
  localparam logic [DIV_WIDTH-1:0] MIN_R       = DIV_WIDTH'(MIN_RATIO);

  state_t               state;
  state_t               state_next;
  logic [DIV_WIDTH-1:0] n_a;
  logic [DIV_WIDTH-1:0] n_p;
  logic [DIV_WIDTH-1:0] ratio_clamped;
  logic                 div_ack_q;
  logic                 run;
  logic                 capture;
  logic                 apply_pend;
  logic                 apply_direct;
  logic                 wrap;
  logic                 core_clk_out;
  logic                 core_tick;

  assign ratio_clamped = (bus.div_ratio < MIN_R) ? MIN_R : bus.div_ratio;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= ST_STOP;
    end else begin
      state <= state_next;
    end
  end

  // Next state: en gates everything, a load moves RUN to PEND, a wrap retires PEND
  always_comb begin
    state_next = state;
    unique case (state)
      ST_STOP: if (bus.en) state_next = ST_RUN;
      ST_RUN: begin
        if (!bus.en)           state_next = ST_STOP;
        else if (bus.div_load) state_next = ST_PEND;
      end
      ST_PEND: begin
        if (!bus.en)  state_next = ST_STOP;
        else if (wrap) state_next = ST_RUN;
      end
      default: state_next = ST_STOP;
    endcase
  end

  // Control decode: a stopped or stopping divider applies ratios at once,
  // a running one defers them to the period boundary
  always_comb begin
    run          = 1'b0;
    capture      = 1'b0;
    apply_pend   = 1'b0;
    apply_direct = 1'b0;
    unique case (state)
      ST_STOP: apply_direct = bus.div_load;
      ST_RUN: begin
        run          = bus.en;
        capture      = bus.en && bus.div_load;
        apply_direct = !bus.en && bus.div_load;
      end
      ST_PEND: begin
        run        = bus.en;
        apply_pend = !bus.en || wrap;
      end
      default: ;
    endcase
  end

  // Active/pending ratio registers and the acknowledge pulse
  always_ff @(posedge clk_in) begin
    if (rst) begin
      n_a       <= RST_CLAMPED;
      n_p       <= RST_CLAMPED;
      div_ack_q <= 1'b0;
    end else begin
      div_ack_q <= apply_pend || apply_direct;
      if (capture)           n_p <= ratio_clamped;
      if (apply_pend)        n_a <= n_p;
      else if (apply_direct) n_a <= ratio_clamped;
    end
  end

  clk_div_core #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_core (
    .clk_in  (clk_in),
    .rst     (rst),
    .run     (run),
    .n_a     (n_a),
    .clk_out (core_clk_out),
    .tick    (core_tick),
    .wrap    (wrap)
  );

  assign bus.clk_out = core_clk_out;
  assign bus.tick    = core_tick;
  assign bus.div_ack = div_ack_q;
  assign bus.busy    = (state == ST_PEND);

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog against a period-position model
module tb_clk_div_prog;

  logic clk_in = 1'b0;
  logic rst;

  always #5 clk_in = ~clk_in;

  clk_div_if #(.DIV_WIDTH(8)) bus ();

  clk_div_prog #(
    .DIV_WIDTH (8),
    .RST_RATIO (2)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  int m_na, m_np, m_p;
  bit m_pend, m_run, m_started;
  bit e_clk, e_tick, e_ack;

  function automatic int clampv(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%0b expected=%0b", tag, $time, obs, exp);
    end
  endtask

  // Reference: position p within the current period of length m_na;
  // clk_out is high for the first ceil(N/2) positions once the first period has elapsed.
  task automatic model(input bit r, input bit e, input bit ld, input int c);
    bit was;
    if (r) begin
      m_na = 2; m_np = 2; m_pend = 0; m_run = 0; m_p = 0; m_started = 0;
      e_clk = 0; e_tick = 0; e_ack = 0;
    end else if (!m_run) begin
      e_clk = 0; e_tick = 0; e_ack = ld;
      if (ld) m_na = c;
      if (e) begin m_run = 1; m_p = 0; m_started = 0; end
    end else if (!e) begin
      e_clk = 0; e_tick = 0; e_ack = m_pend || ld;
      if (m_pend) m_na = m_np;
      else if (ld) m_na = c;
      m_pend = 0; m_run = 0;
    end else begin
      was = m_pend; e_ack = 0; e_tick = 0;
      m_p++;
      if (m_p >= m_na) begin
        m_p = 0; m_started = 1; e_tick = 1;
        if (was) begin m_na = m_np; m_pend = 0; e_ack = 1; end
      end
      e_clk = m_started && (m_p < (m_na + 1) / 2);
      if (ld && !was) begin m_np = c; m_pend = 1; end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit ld, input int ratio);
    rst           = r;
    bus.en        = e;
    bus.div_load  = ld;
    bus.div_ratio = 8'(ratio);
    @(posedge clk_in);
    model(r, e, ld, clampv(ratio & 255));
    @(negedge clk_in);
    chk("clk_out", bus.clk_out, e_clk);
    chk("tick",    bus.tick,    e_tick);
    chk("div_ack", bus.div_ack, e_ack);
    chk("busy",    bus.busy,    m_pend);
    bus.div_load = 1'b0;
  endtask

  initial begin
    bit r, e, ld;
    int ratio;
    rst = 1'b1; bus.en = 1'b0; bus.div_load = 1'b0; bus.div_ratio = '0;

    // reset state, then idle
    repeat (3) cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    // N=2 after reset
    repeat (12) cyc(0, 1, 0, 0);
    // N=5 loaded while running
    cyc(0, 1, 1, 5);
    repeat (30) cyc(0, 1, 0, 0);
    // clamped ratios 0 and 1, then the widest ratio
    cyc(0, 1, 1, 0);
    repeat (12) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 1);
    repeat (12) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 255);
    repeat (540) cyc(0, 1, 0, 0);
    // second load while pending is ignored
    cyc(0, 1, 1, 4);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 7);
    repeat (20) cyc(0, 1, 0, 0);
    // en dropped one cycle into a high phase with a ratio pending
    for (int i = 0; i < 10 && !e_tick; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 6);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (20) cyc(0, 1, 0, 0);
    // reset while pending
    cyc(0, 1, 1, 9);
    repeat (3) cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 3);
    repeat (2) cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    // load while stopped
    cyc(0, 0, 1, 3);
    repeat (15) cyc(0, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 999) == 0);
      e  = ($urandom_range(0, 49) != 0);
      ld = ($urandom_range(0, 19) == 0);
      ratio = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 12));
      cyc(r, e, ld, ratio);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter DIV_WIDTH, default 8, width of the ratio field and the period counter.
REQ-002 Parameter RST_RATIO, default 2, active divide ratio after reset.
REQ-003 clk_in  input  1  sole clock; all flops on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run enable; low stops and parks the divider.
REQ-006 div_ratio  input  DIV_WIDTH  requested divide ratio N, unsigned.
REQ-007 div_load  input  1  single-cycle request to capture div_ratio.
REQ-008 div_ack  output  1  one-cycle pulse in the cycle the new ratio takes effect.
REQ-009 busy  output  1  high while a captured ratio is pending.
REQ-010 clk_out  output  1  registered divided clock, glitch-free.
REQ-011 tick  output  1  one-cycle pulse in the cycle clk_out rises (clock-enable for downstream logic).

Function
REQ-012 Active ratio N_a and pending ratio N_p shall be clamped: any value below 2 is stored as 2.
REQ-013 Period counter cnt shall count 0..N_a-1 and wrap to 0 when en=1.
REQ-014 High time H = ceil(N_a/2); clk_out shall be registered from next-cnt < H, giving 50% duty for even N and (N+1)/2 high, (N-1)/2 low for odd N.
REQ-015 tick shall be registered from next-cnt == 0, coincident with the rising edge of clk_out.
REQ-016 The state machine shall have states STOP (en=0), RUN (en=1, busy=0) and PEND (en=1, busy=1).
REQ-017 In STOP, cnt shall be 0 and clk_out, tick and div_ack shall be 0.
REQ-018 STOP->RUN on en=1; the first clk_out rise and tick shall occur N_a cycles after en is first sampled high.
REQ-019 div_load sampled high while busy=0 shall capture clamped div_ratio into N_p and set busy the next cycle (RUN->PEND).
REQ-020 div_load while busy=1 shall be ignored; N_p shall be unchanged.
REQ-021 In PEND, the ratio shall switch only at the period boundary (cnt wrapping to 0): N_a<=N_p, busy<=0, div_ack pulses in the same cycle as tick.
REQ-022 A div_load sampled in the same cycle as a wrap shall not apply at that wrap; it applies at the next wrap.
REQ-023 A div_load sampled in STOP, or a pending ratio when en falls, shall apply on the next cycle with div_ack pulsed and busy cleared.
REQ-024 en falling mid-period shall force clk_out low on the next cycle; a truncated high phase is permitted, and no glitch shorter than one clk_in period shall occur.
REQ-025 clk_out shall never change other than on a clk_in rising edge.

Reset
REQ-026 rst=1 shall set cnt=0, N_a=RST_RATIO (clamped), N_p=RST_RATIO, clk_out=0, tick=0, div_ack=0, busy=0 and state STOP, overriding en and div_load.
REQ-027 Reset mid-operation shall discard any pending ratio without a div_ack.

Structure
REQ-028 Package clk_div_pkg shall hold DIV_WIDTH default, MIN_RATIO=2, RST_RATIO default and the state enumeration.
REQ-029 Sub-module clk_div_core shall contain cnt, the H compare, clk_out and tick; the top holds the state machine and load handshake.

Verification
REQ-030 Reset then en=1, N_a=2: clk_out toggles every cycle, tick every 2nd cycle, first tick 2 cycles after en.
REQ-031 Load N=5 in RUN: busy=1 until the next wrap, then div_ack plus tick, followed by 3 cycles high and 2 cycles low, repeating.
REQ-032 Load N=0 and N=1: both behave as N=2; load N=255: 128 cycles high and 127 cycles low.
REQ-033 Second div_load (N=7) while PEND with N=4: ignored, N_a becomes 4, one div_ack only.
REQ-034 en dropped 1 cycle into a high phase with N_p pending: clk_out=0 next cycle, div_ack next cycle, restart with N_p.
REQ-035 rst asserted in PEND: busy=0, no div_ack, N_a=RST_RATIO, clk_out=0 the next cycle.
